// File: rtl/router_pkg.sv
// Shared router constants: output-port indices, per-dimension direction
// encoding and the flit destination-field offset helper.
package router_pkg;

   localparam int XPOS      = 0;
   localparam int YPOS      = 1;
   localparam int ZPOS      = 2;
   localparam int XNEG      = 3;
   localparam int YNEG      = 4;
   localparam int ZNEG      = 5;
   localparam int EJECT     = 6;
   localparam int NUM_PORTS = 7;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_POS  = 2'd1,
      DIR_NEG  = 2'd2
   } dir_t;

   // LSB of destination field 'field' (0=x, 1=y, 2=z), packed from the flit MSB down.
   function automatic int coord_lsb(input int flit_size, input int coord_w, input int field);
      return flit_size - (field + 1) * coord_w;
   endfunction

endpackage

// File: rtl/torus_route_calc.sv
// Combinational single-dimension torus direction unit: shortest way round a ring
// of DIM nodes from CUR to i_dst, ties at DIM/2 going positive.
module torus_route_calc
   import router_pkg::*;
#(
   parameter int COORD_W = 4,
   parameter int DIM     = 4,
   parameter int CUR     = 0
) (
   input  logic [COORD_W-1:0] i_dst,
   output dir_t               o_dir,
   output logic               o_oor
);

   localparam int DW = COORD_W + 1;
   localparam logic [COORD_W:0] L_DIM  = DW'(DIM);
   localparam logic [COORD_W:0] L_CUR  = DW'(CUR);
   localparam logic [COORD_W:0] L_HALF = DW'(DIM / 2);

   logic [COORD_W:0] w_dst;
   logic [COORD_W:0] w_sum;
   logic [COORD_W:0] w_delta;

   assign w_dst   = {1'b0, i_dst};
   // Adding DIM first keeps the subtraction non-negative, so one conditional
   // subtract gives (dst - cur) mod DIM for any in-range destination.
   assign w_sum   = w_dst + L_DIM - L_CUR;
   assign w_delta = (w_sum >= L_DIM) ? (w_sum - L_DIM) : w_sum;
   assign o_oor   = (w_dst >= L_DIM);

   always_comb begin
      o_dir = DIR_NONE;
      if (w_delta == '0) begin
         o_dir = DIR_NONE;
      end else if (w_delta <= L_HALF) begin
         o_dir = DIR_POS;
      end else begin
         o_dir = DIR_NEG;
      end
   end

endmodule

// File: rtl/torus_input_port.sv
// Torus router input port: routes each arriving flit (X, then Y, then Z) and buffers
// it with its one-hot output request. Optional counters: define TORUS_INPORT_STATS_EN.
module torus_input_port
   import router_pkg::*;
#(
   parameter int FLIT_SIZE  = 128,
   parameter int COORD_W    = 4,
   parameter int DIM_X      = 4,
   parameter int DIM_Y      = 4,
   parameter int DIM_Z      = 4,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0,
   parameter int CUR_Z      = 0,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLIT_SIZE-1:0] in_flit,
   input  logic                 in_valid,
   output logic                 credit_out,
   output logic [FLIT_SIZE-1:0] out_flit,
   output logic [NUM_PORTS-1:0] out_port,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow_err,
   output logic [31:0]          stat_accepted,
   output logic [31:0]          stat_dropped
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int X_LSB = coord_lsb(FLIT_SIZE, COORD_W, 0);
   localparam int Y_LSB = coord_lsb(FLIT_SIZE, COORD_W, 1);
   localparam int Z_LSB = coord_lsb(FLIT_SIZE, COORD_W, 2);
   localparam logic [AW:0] L_DEPTH = CW'(FIFO_DEPTH);

   dir_t                 w_dir_x, w_dir_y, w_dir_z;
   logic                 w_oor_x, w_oor_y, w_oor_z;
   logic [NUM_PORTS-1:0] w_route;

   torus_route_calc #(.COORD_W(COORD_W), .DIM(DIM_X), .CUR(CUR_X)) u_calc_x (
      .i_dst (in_flit[X_LSB +: COORD_W]),
      .o_dir (w_dir_x),
      .o_oor (w_oor_x)
   );

   torus_route_calc #(.COORD_W(COORD_W), .DIM(DIM_Y), .CUR(CUR_Y)) u_calc_y (
      .i_dst (in_flit[Y_LSB +: COORD_W]),
      .o_dir (w_dir_y),
      .o_oor (w_oor_y)
   );

   torus_route_calc #(.COORD_W(COORD_W), .DIM(DIM_Z), .CUR(CUR_Z)) u_calc_z (
      .i_dst (in_flit[Z_LSB +: COORD_W]),
      .o_dir (w_dir_z),
      .o_oor (w_oor_z)
   );

   // An unreachable coordinate is delivered locally rather than flagged.
   always_comb begin
      w_route = '0;
      if (w_oor_x || w_oor_y || w_oor_z) begin
         w_route[EJECT] = 1'b1;
      end else if (w_dir_x == DIR_POS) begin
         w_route[XPOS] = 1'b1;
      end else if (w_dir_x == DIR_NEG) begin
         w_route[XNEG] = 1'b1;
      end else if (w_dir_y == DIR_POS) begin
         w_route[YPOS] = 1'b1;
      end else if (w_dir_y == DIR_NEG) begin
         w_route[YNEG] = 1'b1;
      end else if (w_dir_z == DIR_POS) begin
         w_route[ZPOS] = 1'b1;
      end else if (w_dir_z == DIR_NEG) begin
         w_route[ZNEG] = 1'b1;
      end else begin
         w_route[EJECT] = 1'b1;
      end
   end

   logic [FLIT_SIZE-1:0] r_mem_flit [FIFO_DEPTH];
   logic [NUM_PORTS-1:0] r_mem_port [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 r_credit;
   logic                 r_overflow;
   logic                 w_valid, w_full, w_pop, w_push, w_drop;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == L_DEPTH);
   assign w_pop   = w_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign w_push  = in_valid & (~w_full | w_pop);
   assign w_drop  = in_valid & ~w_push;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_credit   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_credit <= w_pop;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_flit[r_wr_ptr] <= in_flit;
         r_mem_port[r_wr_ptr] <= w_route;
      end
   end

   assign out_valid    = w_valid;
   assign out_flit     = w_valid ? r_mem_flit[r_rd_ptr] : '0;
   assign out_port     = w_valid ? r_mem_port[r_rd_ptr] : '0;
   assign credit_out   = r_credit;
   assign overflow_err = r_overflow;

`ifdef TORUS_INPORT_STATS_EN
   logic [31:0] r_stat_acc;
   logic [31:0] r_stat_drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_acc  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (w_push && (r_stat_acc != '1)) begin
            r_stat_acc <= r_stat_acc + 1'b1;
         end
         if (w_drop && (r_stat_drop != '1)) begin
            r_stat_drop <= r_stat_drop + 1'b1;
         end
      end
   end

   assign stat_accepted = r_stat_acc;
   assign stat_dropped  = r_stat_drop;
`else
   assign stat_accepted = '0;
   assign stat_dropped  = '0;
`endif

endmodule
